// File: rtl/svo_fb_reader_if.sv
// Bus bundle for the framebuffer reader: memory read port plus pixel stream.
//
// Handshakes:
//   Memory request: a read is issued in a cycle where mem_req & mem_gnt.
//     mem_addr holds steady while mem_req is high and mem_gnt is low.
//     Read data returns on mem_rvalid, in the order the reads were issued.
//     There is no backpressure on responses.
//   Pixel stream: a pixel transfers in a cycle where
//     out_axis_tvalid & out_axis_tready. tdata/tuser are stable while
//     tvalid is high and tready is low.
interface svo_fb_reader_if #(
    parameter int ADDR_W = 24
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [23:0]       mem_rdata;
    logic              out_axis_tvalid;
    logic              out_axis_tready;
    logic [23:0]       out_axis_tdata;
    logic              out_axis_tuser;

    // Reader side.
    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_axis_tvalid, out_axis_tdata, out_axis_tuser,
        input  out_axis_tready
    );

    // Memory and pixel-consumer side.
    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_axis_tvalid, out_axis_tdata, out_axis_tuser,
        output out_axis_tready
    );
endinterface

// File: rtl/svo_fb_reader.sv
// Framebuffer reader: walks the frame in raster order, issues one word read
// per pixel and streams the returned pixels out, tagging the frame's first
// pixel with tuser. Read issue is credit-limited so that every outstanding
// read is guaranteed a slot in the pixel FIFO.
module svo_fb_reader #(
    parameter int                H_RES      = 1024,
    parameter int                V_RES      = 600,
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                clr_underflow,
    svo_fb_reader_if.master     bus,
    output logic                underflow,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CNT_W-1:0]  outstanding;
    logic              tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  tq_wr, tq_rd;
    logic [24:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  f_wr, f_rd;
    logic [CNT_W-1:0]  f_cnt;
    logic              sent_any;

    logic              issue, rsp, push, pop, start, flush;
    logic              frame_start, last_pix, tvalid, uf_set;
    logic [CNT_W:0]    in_use;
    logic [24:0]       head;

    // A response only counts when a read is actually in flight, so stray
    // rvalids after a reset are ignored. Responses in DRAIN are dropped.
    assign issue       = bus.mem_req & bus.mem_gnt;
    assign rsp         = bus.mem_rvalid & (outstanding != '0);
    assign push        = rsp & (state == ST_RUN);
    assign pop         = tvalid & bus.out_axis_tready;
    assign start       = (state == ST_IDLE) & enable;
    assign flush       = (state == ST_DRAIN) & (state_next == ST_IDLE);
    assign frame_start = (col == '0) & (row == '0);
    assign last_pix    = (col == COL_LAST) & (row == ROW_LAST);
    assign in_use      = {1'b0, f_cnt} + {1'b0, outstanding};
    assign head        = fifo_mem[f_rd];
    assign tvalid      = (state == ST_RUN) & (f_cnt != '0);
    assign uf_set      = (state == ST_RUN) & bus.out_axis_tready
                         & (f_cnt == '0) & sent_any;

    // Outputs are gated so that reset and idle show zeros, not stale FIFO data.
    assign bus.mem_req         = (state == ST_RUN) & (in_use < CREDITS);
    assign bus.mem_addr        = addr;
    assign bus.out_axis_tvalid = tvalid;
    assign bus.out_axis_tdata  = tvalid ? head[23:0] : 24'd0;
    assign bus.out_axis_tuser  = tvalid ? head[24] : 1'b0;
    assign busy                = (state != ST_IDLE);
    assign dbg_state           = state;

    // Next-state logic. DRAIN leaves as soon as the last in-flight read
    // returns (the final response is accepted on the transition edge).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (enable) state_next = ST_RUN;
            ST_RUN:   if (!enable) state_next = ST_DRAIN;
            ST_DRAIN: if ((outstanding == '0) ||
                          ((outstanding == CNT_W'(1)) && rsp))
                          state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Raster position and read address; wraps to the frame origin after the
    // last pixel of the frame is issued.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr <= BASE_ADDR;
            col  <= '0;
            row  <= '0;
        end else if (start || (issue && last_pix)) begin
            addr <= BASE_ADDR;
            col  <= '0;
            row  <= '0;
        end else if (issue) begin
            addr <= addr + ADDR_W'(1);
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // In-flight read count and tag-queue pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding <= '0;
            tq_wr       <= '0;
            tq_rd       <= '0;
        end else begin
            case ({issue, rsp})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (start) begin
                tq_wr <= '0;
                tq_rd <= '0;
            end else begin
                if (issue) tq_wr <= tq_wr + PTR_W'(1);
                if (rsp)   tq_rd <= tq_rd + PTR_W'(1);
            end
        end
    end

    // Storage for tags and pixels; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[tq_wr] <= frame_start;
        if (push)  fifo_mem[f_wr] <= {tag_mem[tq_rd], bus.mem_rdata};
    end

    // Pixel FIFO pointers and occupancy; emptied when DRAIN finishes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else if (flush) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) f_wr <= f_wr + PTR_W'(1);
            if (pop)  f_rd <= f_rd + PTR_W'(1);
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + CNT_W'(1);
                2'b01:   f_cnt <= f_cnt - CNT_W'(1);
                default: f_cnt <= f_cnt;
            endcase
        end
    end

    // Sticky underflow: armed only after the first pixel of this run went out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sent_any  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (start)    sent_any <= 1'b0;
            else if (pop) sent_any <= 1'b1;
            if (uf_set)             underflow <= 1'b1;
            else if (clr_underflow) underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_svo_fb_reader.sv
// Directed bench for svo_fb_reader: a latency-programmable memory model
// pushes the expected pixel for every issued read into exp_q, and a stream
// monitor pops and compares on every accepted pixel.
module tb_svo_fb_reader;
    localparam int          H    = 4;
    localparam int          V    = 2;
    localparam int          AW   = 24;
    localparam int          D    = 16;
    localparam int          NPIX = H * V;
    localparam logic [23:0] BASE = 24'h000100;

    typedef struct {
        logic [23:0] addr;
        int          due;
    } pend_t;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       enable = 1'b0;
    logic       clr_underflow = 1'b0;
    logic       underflow, busy;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    svo_fb_reader_if #(.ADDR_W(AW)) bus ();

    svo_fb_reader #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .clr_underflow(clr_underflow), .bus(bus),
        .underflow(underflow), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [24:0] exp_q[$];
    pend_t       pend_q[$];
    int          total = 0;
    int          bad = 0;
    int          npop = 0;
    int          lat = 2;
    bit          gnt_on = 1'b1;
    int          cyc = 0;
    int          rv_count = 0;
    int          exp_idx = 0;
    logic [23:0] exp_addr = BASE;

    function automatic logic [23:0] pix_of(logic [23:0] a);
        return {a[7:0] + 8'h40, ~a[7:0], a[11:4]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req"},   32'(bus.mem_req), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 32'(BASE));
        chk({tag, "_tvalid"}, 32'(bus.out_axis_tvalid), 0);
        chk({tag, "_tdata"}, 32'(bus.out_axis_tdata), 0);
        chk({tag, "_tuser"}, 32'(bus.out_axis_tuser), 0);
        chk({tag, "_uf"},    32'(underflow), 0);
        chk({tag, "_busy"},  32'(busy), 0);
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: busy=%0d required 0", tag, busy);
        end
    endtask

    task automatic restart_model();
        exp_q.delete();
        exp_addr = BASE;
        exp_idx  = 0;
    endtask

    // ---------------- memory model (driver of the memory side) ----------------
    initial begin
        pend_t p;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 24'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                pend_q.delete();
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 24'd0;
                exp_addr       = BASE;
                exp_idx        = 0;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 24'd0;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    p = pend_q.pop_front();
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = pix_of(p.addr);
                    rv_count++;
                end
                bus.mem_gnt = gnt_on;
                if (bus.mem_req && bus.mem_gnt) begin
                    chk("issue_addr", 32'(bus.mem_addr), 32'(exp_addr));
                    p.addr = bus.mem_addr;
                    p.due  = cyc + lat;
                    pend_q.push_back(p);
                    exp_q.push_back({(exp_idx == 0), pix_of(exp_addr)});
                    exp_idx  = (exp_idx == NPIX - 1) ? 0 : exp_idx + 1;
                    exp_addr = BASE + 24'(exp_idx);
                end
            end
        end
    end

    // ---------------- stream monitor ----------------
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (resetn && bus.out_axis_tvalid && bus.out_axis_tready) begin
                npop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pixel_unexpected: got %0h expected none",
                             {bus.out_axis_tuser, bus.out_axis_tdata});
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'({bus.out_axis_tuser, bus.out_axis_tdata}), 32'(e));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  pops_before;
        bit  seen_last, done;
        bus.out_axis_tready = 1'b0;
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        resetn = 1'b1;
        step();

        // Basic streaming over more than one frame, latency 2.
        lat = 2;
        gnt_on = 1'b1;
        bus.out_axis_tready = 1'b1;
        enable = 1'b1;
        repeat (30) step();
        chk("p1_underflow", 32'(underflow), 0);
        chk("p1_enough_pixels", 32'(npop >= NPIX + 1), 1);
        chk("p1_state_run", 32'(dbg_state), 1);

        // Consumer backpressure: credits must cap in-flight + buffered at D.
        bus.out_axis_tready = 1'b0;
        repeat (40) step();
        chk("p2_req_dropped", 32'(bus.mem_req), 0);
        chk("p2_credit_total", 32'(exp_q.size()), D);
        chk("p2_tvalid_held", 32'(bus.out_axis_tvalid), 1);
        bus.out_axis_tready = 1'b1;
        repeat (30) step();
        chk("p2_underflow", 32'(underflow), 0);

        // Grant stall: address must hold while the request waits.
        gnt_on = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p3_addr_hold", 32'(bus.mem_addr), 32'(exp_addr));
            chk("p3_req_hold", 32'(bus.mem_req), 1);
        end
        gnt_on = 1'b1;
        repeat (20) step();

        // Disable with exactly three reads in flight.
        lat = 10;
        gnt_on = 1'b0;
        repeat (20) step();
        chk("p4_drained", 32'(exp_q.size()), 0);
        rv_count = 0;
        gnt_on = 1'b1;
        repeat (3) step();
        gnt_on = 1'b0;
        enable = 1'b0;
        seen_last = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            #3;
            if (rv_count < 3) begin
                chk("p4_busy_drain", 32'(busy), 1);
                chk("p4_state_drain", 32'(dbg_state), 2);
            end else if (!seen_last) begin
                chk("p4_busy_last_rsp", 32'(busy), 1);
                seen_last = 1'b1;
            end else begin
                chk("p4_idle_busy", 32'(busy), 0);
                chk("p4_idle_tvalid", 32'(bus.out_axis_tvalid), 0);
                chk("p4_idle_state", 32'(dbg_state), 0);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL p4_drain_timeout: rv_count=%0d required 3", rv_count);
        end
        chk("p4_three_rsp", 32'(rv_count), 3);
        restart_model();
        chk("p4_uf_sticky", 32'(underflow), 1);
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        step();
        chk("p4_uf_cleared", 32'(underflow), 0);

        // Re-enable with latency 20: restart at BASE with tuser, then underflow.
        lat = 20;
        gnt_on = 1'b1;
        pops_before = npop;
        enable = 1'b1;
        repeat (15) step();
        chk("p5_uf_before_first", 32'(underflow), 0);
        repeat (45) step();
        chk("p5_uf_set", 32'(underflow), 1);
        chk("p5_pixels_out", 32'(npop > pops_before), 1);
        repeat (10) step();
        chk("p5_uf_holds", 32'(underflow), 1);
        enable = 1'b0;
        wait_idle("p5");
        restart_model();
        chk("p5_uf_idle_holds", 32'(underflow), 1);
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        step();
        chk("p5_uf_cleared", 32'(underflow), 0);

        // Reset mid-line with reads in flight.
        lat = 3;
        enable = 1'b1;
        repeat (6) step();
        chk("p6_midline_addr_moved", 32'(bus.mem_addr != BASE), 1);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        chk_reset_outputs("p6_rst");
        repeat (3) @(negedge clk);
        #1;
        resetn = 1'b1;
        pops_before = npop;
        repeat (25) step();
        chk("p6_pixels_after_reset", 32'(npop > pops_before), 1);
        chk("p6_underflow", 32'(underflow), 0);

        enable = 1'b0;
        wait_idle("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/svo_fb_reader.md
SVO_FB_READER -- requirements
Module: svo_fb_reader

Interface
REQ-001 SHALL have parameter H_RES, default 1024, active pixels per line.
REQ-002 SHALL have parameter V_RES, default 600, active lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 0, word address of pixel (0,0); ADDR_W bits wide.
REQ-004 SHALL have parameter ADDR_W, default 24, memory word-address width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, >=4).
REQ-006 Ports:
clk  in  1  pixel clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  level; 1 = stream frames
clr_underflow  in  1  pulse; clears underflow flag
mem_req  out  1  read request valid
mem_addr  out  ADDR_W  read word address
mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt = issue)
mem_rvalid  in  1  read data valid; responses in issue order
mem_rdata  in  24  pixel {R[23:16],G[15:8],B[7:0]}
out_axis_tvalid  out  1  pixel valid
out_axis_tready  in  1  consumer accepts
out_axis_tdata  out  24  pixel
out_axis_tuser  out  1  1 on first pixel of frame
underflow  out  1  sticky underflow flag
busy  out  1  1 when state != IDLE

Function
REQ-007 SHALL implement states IDLE, RUN, DRAIN.
REQ-008 IDLE -> RUN when enable=1; pixel index and line/column counters set to 0, address to BASE_ADDR.
REQ-009 RUN -> DRAIN when enable=0; DRAIN -> IDLE when outstanding count = 0, FIFO flushed on that transition.
REQ-010 In RUN, mem_req SHALL be 1 iff (fifo_count + outstanding) < FIFO_DEPTH; mem_req SHALL be 0 in IDLE and DRAIN.
REQ-011 mem_addr SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-012 On issue, address SHALL increment by 1; after issuing pixel H_RES*V_RES-1 it SHALL wrap to BASE_ADDR and counters to 0.
REQ-013 Each issue SHALL record a frame-start tag (1 for pixel 0) in an in-order tag queue of depth FIFO_DEPTH; tag accompanies matching response into FIFO as tuser.
REQ-014 outstanding SHALL increment on issue, decrement on mem_rvalid, unchanged on simultaneous both; width holds 0..FIFO_DEPTH.
REQ-015 mem_rvalid SHALL write {tag, mem_rdata} into FIFO same cycle; credit rule guarantees no overflow; in DRAIN responses are accepted and discarded.
REQ-016 out_axis_tvalid SHALL be 1 iff FIFO non-empty and state=RUN; tdata/tuser driven from FIFO head (first-word-fall-through), popped on tvalid & tready.
REQ-017 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged; push into empty FIFO SHALL appear on out_axis_tvalid the next cycle.
REQ-018 underflow SHALL set when state=RUN, out_axis_tready=1, FIFO empty, and at least one pixel has been output since entering RUN; clears only on clr_underflow (set wins if simultaneous).
REQ-019 Output stream SHALL never reorder, duplicate or drop pixels while in RUN.
REQ-020 Sustained throughput SHALL be 1 pixel/clk when mem_gnt=1 every cycle and read latency <= FIFO_DEPTH-2.

Reset
REQ-021 resetn=0 SHALL asynchronously force: state IDLE, mem_req=0, mem_addr=BASE_ADDR, out_axis_tvalid=0, out_axis_tdata=0, out_axis_tuser=0, underflow=0, busy=0, FIFO, tag queue, outstanding and counters cleared.
REQ-022 Reset mid-frame SHALL discard in-flight responses; mem_rvalid during reset ignored; next frame after reset starts at BASE_ADDR with tuser=1.

Verification
REQ-023 H_RES=4, V_RES=2, BASE_ADDR=0x100, mem latency 2, gnt=1, tready=1, enable=1 -> addresses 0x100..0x107 then 0x100; tuser=1 on pixels 0 and 8 only; no underflow.
REQ-024 tready=0 for 40 cycles in RUN -> mem_req drops once fifo_count+outstanding=16; no data lost; order preserved on resume.
REQ-025 mem_gnt=0 for 5 cycles -> mem_addr constant, outstanding unchanged.
REQ-026 Read latency 20 with FIFO_DEPTH=16, tready=1 after first pixel -> underflow=1 and holds; clr_underflow pulse -> 0.
REQ-027 enable=0 with 3 outstanding -> DRAIN, busy=1 until third mem_rvalid, then IDLE, tvalid=0; re-enable -> restarts at BASE_ADDR, tuser=1.
REQ-028 resetn=0 mid-line with outstanding reads -> all outputs at reset values immediately; after release and enable, first pixel is BASE_ADDR data.
